// File: rtl/dma_uart_tx_if.sv
// dma_uart_tx_if: shared RAM bus and arbiter handshake seen by the DMA transmitter.
//   master (DMA side): drives Bus_req, Address, Cs, Oen; receives Bus_grant, Databus.
//   slave  (arbiter/RAM side): the mirror image.
interface dma_uart_tx_if;
  logic       Bus_req;
  logic       Bus_grant;
  logic [7:0] Address;
  logic [7:0] Databus;
  logic       Cs;
  logic       Oen;

  modport master (
    output Bus_req,
    output Address,
    output Cs,
    output Oen,
    input  Bus_grant,
    input  Databus
  );

  modport slave (
    input  Bus_req,
    input  Address,
    input  Cs,
    input  Oen,
    output Bus_grant,
    output Databus
  );
endinterface

// File: rtl/dma_uart_tx.sv
// dma_uart_tx: on a CPU start pulse, acquires the RAM bus, reads the bytes at
// MSB_ADDR then LSB_ADDR and sends each over an internal 8N1 UART on TXD,
// then releases the bus and raises Dma_Ready.
// Ports:
//   Clk, Rst   - clock, synchronous active-high reset
//   Ena, Start - DMA enable and one-cycle start request
//   bus        - RAM bus / arbiter (Bus_req, Bus_grant, Address, Databus, Cs, Oen)
//   Dma_Ready  - high while idle
//   TXD        - serial output, idles high
//   TX_Ready   - UART end-of-transmission / idle flag
module dma_uart_tx #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter logic [7:0]  MSB_ADDR    = 8'h04,
  parameter logic [7:0]  LSB_ADDR    = 8'h05
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Ena,
  input  logic Start,
  dma_uart_tx_if.master bus,
  output logic Dma_Ready,
  output logic TXD,
  output logic TX_Ready
);

  localparam int unsigned CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_RD_MSB,
    S_TX_MSB,
    S_WAIT_MSB,
    S_RD_LSB,
    S_TX_LSB,
    S_WAIT_LSB,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid;

  // UART state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;    // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             eot_q, eot_d;

  // ---------------- DMA FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  // ---------------- DMA FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (Start && Ena) state_d = S_REQ;
      S_REQ:      if (bus.Bus_grant) state_d = S_RD_MSB;
      S_RD_MSB:   state_d = S_TX_MSB;
      S_TX_MSB:   state_d = S_WAIT_MSB;
      S_WAIT_MSB: if (eot_q) state_d = S_RD_LSB;
      S_RD_LSB:   state_d = S_TX_LSB;
      S_TX_LSB:   state_d = S_WAIT_LSB;
      S_WAIT_LSB: if (eot_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------- DMA FSM: outputs ----------------
  always_comb begin
    bus.Address = '0;
    bus.Cs      = 1'b0;
    bus.Oen     = 1'b1;
    bus.Bus_req = 1'b0;
    Dma_Ready   = 1'b0;
    tx_valid    = 1'b0;
    tx_data_d   = tx_data_q;
    unique case (state_q)
      S_IDLE: Dma_Ready = 1'b1;
      S_REQ, S_WAIT_MSB, S_WAIT_LSB: bus.Bus_req = 1'b1;
      S_RD_MSB: begin
        bus.Bus_req = 1'b1;
        bus.Address = MSB_ADDR;
        bus.Cs      = 1'b1;
        bus.Oen     = 1'b0;
        tx_data_d   = bus.Databus;
      end
      S_RD_LSB: begin
        bus.Bus_req = 1'b1;
        bus.Address = LSB_ADDR;
        bus.Cs      = 1'b1;
        bus.Oen     = 1'b0;
        tx_data_d   = bus.Databus;
      end
      S_TX_MSB, S_TX_LSB: begin
        bus.Bus_req = 1'b1;
        tx_valid    = 1'b1;
      end
      S_DONE: ;
      default: ;
    endcase
  end

  // ---------------- UART 8N1 transmitter ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      eot_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      eot_q   <= eot_d;
    end
  end

  // TXD is registered: the value for the next bit is loaded on the edge that
  // ends the current bit, so each bit is exactly CLK_PER_BIT cycles wide.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    eot_d   = eot_q;
    if (eot_q) begin
      if (tx_valid) begin
        shift_d = tx_data_q;
        txd_d   = 1'b0;
        eot_d   = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
      end
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        eot_d = 1'b1;
        txd_d = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        txd_d = (bit_q == 4'd8) ? 1'b1 : shift_q[bit_q[2:0]];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign TXD      = txd_q;
  assign TX_Ready = eot_q;

endmodule

// File: tb/tb_dma_uart_tx.sv
module tb_dma_uart_tx;
  localparam int unsigned CPB = 4;

  logic Clk = 1'b0;
  logic Rst, Ena, Start;
  logic Dma_Ready, TXD, TX_Ready;
  logic [7:0] m_msb, m_lsb, noise;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  exp_bytes[$];
  logic [7:0]  exp_addr[$];
  int unsigned f_start[$];
  int unsigned f_end[$];

  dma_uart_tx_if bus_if();

  // RAM model: only addresses 0x04/0x05 hold data; anything else is noise
  assign bus_if.Databus = (bus_if.Address == 8'h04) ? m_msb :
                          (bus_if.Address == 8'h05) ? m_lsb : noise;

  dma_uart_tx #(.CLK_PER_BIT(CPB), .MSB_ADDR(8'h04), .LSB_ADDR(8'h05)) dut (
    .Clk(Clk), .Rst(Rst), .Ena(Ena), .Start(Start), .bus(bus_if.master),
    .Dma_Ready(Dma_Ready), .TXD(TXD), .TX_Ready(TX_Ready)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    noise <= 8'($urandom);
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: each chip-select cycle must match the next expected address
  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus_if.Cs === 1'b1) begin
        if (exp_addr.size() == 0) check_eq("cs_unexpected", bus_if.Cs, 0);
        else begin
          check_eq("rd_addr", bus_if.Address, exp_addr.pop_front());
          check_eq("rd_oen", bus_if.Oen, 0);
          check_eq("rd_busreq", bus_if.Bus_req, 1);
        end
      end else begin
        check_eq("idle_bus", {bus_if.Address, bus_if.Oen}, {8'h00, 1'b1});
      end
    end
  end

  // Frame monitor: samples every cycle of a frame, decodes, and scores the byte
  initial begin
    logic [10*CPB-1:0] smp;
    logic [7:0] b;
    logic v;
    bit aborted, bad_shape;
    forever begin
      @(negedge Clk);
      if (!Rst && TXD === 1'b0) begin
        aborted = 0;
        f_start.push_back(cyc);
        check_eq("eot_low_at_start", TX_Ready, 0);
        smp[0] = TXD;
        for (int i = 1; i < 10*CPB; i++) begin
          @(negedge Clk);
          if (Rst) aborted = 1;
          smp[i] = TXD;
        end
        if (!aborted) begin
          check_eq("eot_low_at_end", TX_Ready, 0);
          @(negedge Clk);
          if (Rst) aborted = 1;
        end
        if (!aborted) begin
          check_eq("eot_high_after", TX_Ready, 1);
          f_end.push_back(cyc);
          bad_shape = 0;
          b = '0;
          for (int k = 0; k < 10; k++) begin
            v = smp[k*CPB];
            for (int c = 1; c < CPB; c++)
              if (smp[k*CPB+c] !== v) bad_shape = 1;
            if (k == 0 && v !== 1'b0) bad_shape = 1;
            else if (k == 9 && v !== 1'b1) bad_shape = 1;
            else if (k > 0 && k < 9) b[k-1] = v;
          end
          check_eq("frame_shape", bad_shape, 0);
          if (exp_bytes.size() == 0) check_eq("frame_unexpected", exp_bytes.size(), 1);
          else check_eq("frame_byte", b, exp_bytes.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_addr"}, bus_if.Address, 8'h00);
    check_eq({tag, "_cs"}, bus_if.Cs, 0);
    check_eq({tag, "_oen"}, bus_if.Oen, 1);
    check_eq({tag, "_busreq"}, bus_if.Bus_req, 0);
    check_eq({tag, "_dmardy"}, Dma_Ready, 1);
    check_eq({tag, "_txd"}, TXD, 1);
    check_eq({tag, "_txrdy"}, TX_Ready, 1);
  endtask

  task automatic pulse_start(input logic en);
    Ena = en;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic idle_check(input string name, input int unsigned n);
    bit ok = 1;
    repeat (n) begin
      @(negedge Clk);
      if (bus_if.Bus_req !== 1'b0 || TXD !== 1'b1 || Dma_Ready !== 1'b1) ok = 0;
    end
    check_eq(name, ok, 1);
  endtask

  task automatic transfer(input int unsigned gd, input bit busy, input logic [7:0] mb, input logic [7:0] lb);
    bit ok;
    int unsigned n, rdy;
    m_msb = mb;
    m_lsb = lb;
    exp_bytes.push_back(mb);
    exp_bytes.push_back(lb);
    exp_addr.push_back(8'h04);
    exp_addr.push_back(8'h05);
    f_start.delete();
    f_end.delete();
    pulse_start(1'b1);
    check_eq("start_busreq", bus_if.Bus_req, 1);
    check_eq("start_dmardy", Dma_Ready, 0);
    ok = 1;
    repeat (gd) begin
      @(negedge Clk);
      if (bus_if.Bus_req !== 1'b1 || bus_if.Cs !== 1'b0 || TXD !== 1'b1 || Dma_Ready !== 1'b0) ok = 0;
    end
    check_eq("req_hold", ok, 1);
    Ena = 1'($urandom_range(0, 1));
    bus_if.Bus_grant = 1'b1;
    @(negedge Clk);
    bus_if.Bus_grant = 1'b0;
    if (busy) begin
      n = 0;
      while (TX_Ready !== 1'b0 && n < 20) begin @(negedge Clk); n++; end
      check_eq("busy_wait_frame", TX_Ready, 0);
      repeat (5) @(negedge Clk);
      bus_if.Bus_grant = 1'b1;
      pulse_start(1'b1);
      bus_if.Bus_grant = 1'b0;
    end
    n = 0;
    while (Dma_Ready !== 1'b1 && n < 2000) begin @(negedge Clk); n++; end
    check_eq("done_timeout", Dma_Ready, 1);
    rdy = cyc;
    check_eq("frame_count", f_end.size(), 2);
    if (f_end.size() >= 2 && f_start.size() >= 2) begin
      check_eq("lsb_gap", f_start[1] - f_end[0], 3);
      check_eq("ready_lag", rdy - f_end[1], 2);
    end
    Ena = 1'b1;
    idle_check("post_idle", 20);
  endtask

  initial begin
    int unsigned n;
    Rst = 1'b1; Ena = 1'b0; Start = 1'b0; bus_if.Bus_grant = 1'b0;
    m_msb = '0; m_lsb = '0;
    repeat (5) @(negedge Clk);
    check_reset_vals("rst");
    Rst = 1'b0;
    @(negedge Clk);

    transfer(10, 0, 8'hAA, 8'hAA);
    transfer(3, 0, 8'hAA, 8'hBB);

    // Enable gating, plus a stray grant while idle
    pulse_start(1'b0);
    bus_if.Bus_grant = 1'b1;
    @(negedge Clk);
    bus_if.Bus_grant = 1'b0;
    idle_check("ena_gate", 50);

    transfer(1000, 0, 8'($urandom), 8'($urandom));
    transfer(5, 1, 8'($urandom), 8'($urandom));
    for (int t = 0; t < 6; t++)
      transfer($urandom_range(0, 20), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    // Reset in the middle of the MSB frame
    m_msb = 8'($urandom);
    exp_bytes.push_back(m_msb);
    exp_addr.push_back(8'h04);
    exp_addr.push_back(8'h05);
    pulse_start(1'b1);
    bus_if.Bus_grant = 1'b1;
    @(negedge Clk);
    bus_if.Bus_grant = 1'b0;
    n = 0;
    while (TX_Ready !== 1'b0 && n < 20) begin @(negedge Clk); n++; end
    check_eq("rst_wait_frame", TX_Ready, 0);
    repeat (12) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check_reset_vals("midrst");
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    exp_bytes.delete();
    exp_addr.delete();
    idle_check("after_rst_quiet", 100);

    transfer(2, 0, 8'($urandom), 8'($urandom));

    repeat (10) @(negedge Clk);
    check_eq("leftover_bytes", exp_bytes.size(), 0);
    check_eq("leftover_addr", exp_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
